// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the fetch unit's control strobes, instruction-memory bus and
//   status outputs so the unit exposes one port besides clk/reset.
//   Modports:
//     master - the fetch unit. It takes the control strobes and memory
//              read data, and drives the memory request, PC, IR and status.
//     slave  - the environment: the control FSM plus instruction memory.
//   Signals:
//     PC_clr, PC_up, IR_ld   control strobes from the FSM
//     imem_data, imem_ack    memory read data and completion strobe
//     imem_addr, imem_rd     memory read address and request
//     PC, IR                 program counter and instruction register
//     IR_valid               IR holds a completed fetch
//     fetch_busy             a fetch is outstanding
//     fetch_err              sticky fetch-timeout flag
interface instr_fetch_unit_if #(
  parameter int PC_W   = 7,
  parameter int DATA_W = 16
);
  logic              PC_clr;
  logic              PC_up;
  logic              IR_ld;
  logic [DATA_W-1:0] imem_data;
  logic              imem_ack;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rd;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] IR;
  logic              IR_valid;
  logic              fetch_busy;
  logic              fetch_err;

  modport master (
    input  PC_clr, PC_up, IR_ld, imem_data, imem_ack,
    output imem_addr, imem_rd, PC, IR, IR_valid, fetch_busy, fetch_err
  );

  modport slave (
    output PC_clr, PC_up, IR_ld, imem_data, imem_ack,
    input  imem_addr, imem_rd, PC, IR, IR_valid, fetch_busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the program counter and instruction register that feed the
//   processor control FSM. It acts on the FSM's PC_clr / PC_up / IR_ld
//   strobes and fetches one instruction word per IR_ld over a
//   variable-latency rd/ack handshake. All outputs are registered.
//   Ports:
//     clk    rising-edge system clock
//     reset  asynchronous, active-high reset
//     bus    instr_fetch_unit_if.master. It carries the control strobes,
//            the memory bus, PC, IR and the status flags.
//   Optional feature (macro FETCH_TIMEOUT_EN):
//     When defined, a fetch with no ack for TIMEOUT consecutive WAIT cycles
//     is abandoned. The unit then loads the HALT opcode 16'h5000 into IR
//     and sets the sticky fetch_err flag. When undefined, WAIT lasts until
//     ack, PC_clr or reset, and fetch_err is tied low.
module instr_fetch_unit #(
  parameter int PC_W    = 7,
  parameter int DATA_W  = 16
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]        state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   addr_reg;
  logic [DATA_W-1:0] ir_reg;
  logic              valid_reg;
  logic              rd_reg;
  logic              busy_reg;
  // Records a PC_up that arrived together with IR_ld. The increment is
  // applied only when the fetch completes, so the address stays stable.
  logic              up_pend_reg;

`ifdef FETCH_TIMEOUT_EN
  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] HALT_OP = DATA_W'(16'h5000);
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      addr_reg    <= '0;
      ir_reg      <= '0;
      valid_reg   <= 1'b0;
      rd_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      up_pend_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // imem_ack is deliberately ignored here. A late ack from an
          // aborted fetch must not load IR.
          if (bus.PC_clr) begin
            pc_reg    <= '0;
            valid_reg <= 1'b0;
          end else if (bus.IR_ld) begin
            addr_reg    <= pc_reg;
            rd_reg      <= 1'b1;
            busy_reg    <= 1'b1;
            valid_reg   <= 1'b0;
            up_pend_reg <= bus.PC_up;
            state_reg   <= WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_reg     <= '0;
`endif
          end else if (bus.PC_up) begin
            pc_reg <= pc_reg + 1'b1;   // wraps modulo 2^PC_W
          end
        end

        WAIT: begin
          // IR_ld and PC_up are not queued while a fetch is outstanding.
          // PC_clr takes priority even over an ack in the same cycle.
          if (bus.PC_clr) begin
            pc_reg    <= '0;
            valid_reg <= 1'b0;
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.imem_ack) begin
            ir_reg    <= bus.imem_data;
            valid_reg <= 1'b1;
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
            if (up_pend_reg) begin
              pc_reg <= pc_reg + 1'b1;
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle with no ack. Hand the FSM
            // a HALT so that it stops cleanly. PC is left unchanged.
            err_reg   <= 1'b1;
            ir_reg    <= HALT_OP;
            valid_reg <= 1'b1;
            rd_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.imem_addr  = addr_reg;
  assign bus.imem_rd    = rd_reg;
  assign bus.PC         = pc_reg;
  assign bus.IR         = ir_reg;
  assign bus.IR_valid   = valid_reg;
  assign bus.fetch_busy = busy_reg;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err  = err_reg;
`else
  assign bus.fetch_err  = 1'b0;
`endif

endmodule
